vecmat_row_sched: RTL and testbench

//  Row scheduler for the shared LSTM vector-matrix unit.
//  On start, walks the weight-row addresses 0..N-1 and strobes the vecmat datapath once per row.

---
 rtl/vecmat_row_sched_if.sv | 37 +++
 rtl/vecmat_row_sched.sv | 191 +++++++++++++++++++
 tb/tb_vecmat_row_sched.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vecmat_row_sched_if.sv
// Result/datapath bundle for vecmat_row_sched: weight RAM read, datapath issue/return and result stream.
// The scheduler takes the master side; the weight RAM, datapath and gate logic sit on the slave side.
interface vecmat_row_sched_if #(
    parameter int ADDRW = 7,
    parameter int DW    = 16
);
    logic             w_rd_en;
    logic [ADDRW-1:0] w_addr;
    logic             vm_en;
    logic [DW-1:0]    vm_result;
    logic             res_valid;
    logic             res_ready;
    logic [DW-1:0]    res_data;
    logic [ADDRW-1:0] res_idx;

    modport master (
        output w_rd_en,
        output w_addr,
        output vm_en,
        output res_valid,
        output res_data,
        output res_idx,
        input  vm_result,
        input  res_ready
    );

    modport slave (
        input  w_rd_en,
        input  w_addr,
        input  vm_en,
        input  res_valid,
        input  res_data,
        input  res_idx,
        output vm_result,
        output res_ready
    );
endinterface

// File: rtl/vecmat_row_sched.sv
// Row scheduler for the shared LSTM vector-matrix unit: issues rows 0..N-1, buffers results in order.
// Optional abort input is built when VECMAT_SCHED_ABORT_EN is defined.
module vecmat_row_sched #(
    parameter int NROWS  = 100,
    parameter int ADDRW  = 7,
    parameter int DW     = 16,
    parameter int LAT    = 2,
    parameter int FDEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ADDRW-1:0] nrows_cfg,
`ifdef VECMAT_SCHED_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    vecmat_row_sched_if.master bus
);

    localparam int CW = $clog2(FDEPTH + 1);
    localparam int SW = CW + 1;
    localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDRW-1:0] last_row;
    logic [ADDRW-1:0] w_addr_q;
    logic             vm_en_q;
    logic [ADDRW-1:0] vm_idx;
    logic [LAT-1:0]   vld_sr;
    logic [ADDRW-1:0] idx_sr [LAT];

    logic [CW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DW-1:0]    mem_data [FDEPTH];
    logic [ADDRW-1:0] mem_idx  [FDEPTH];

    logic             issue;
    logic             issue_ok;
    logic             pop;
    logic             fifo_wr;
    logic             accept_last;
    logic             abort_hit;
    logic [SW-1:0]    credit_used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef VECMAT_SCHED_ABORT_EN
    assign abort_hit = abort && ((state == ISSUE) || (state == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    // A row popped this cycle frees its slot in time for the next issue, which keeps
    // the pipeline at one row per cycle when FDEPTH == LAT+2 and the consumer keeps up.
    always_comb begin
        pop         = (fifo_count != '0) && bus.res_ready;
        fifo_wr     = vld_sr[LAT-1];
        accept_last = pop && (mem_idx[rd_ptr] == last_row);
        credit_used = SW'(inflight) + SW'(fifo_count) - SW'(pop);
        issue_ok    = credit_used < SW'(FDEPTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                issue = issue_ok;
                if (issue_ok && (w_addr_q == last_row)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (accept_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (abort_hit) begin
            issue      = 1'b0;
            next_state = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_row   <= '0;
            w_addr_q   <= '0;
            vm_en_q    <= 1'b0;
            vm_idx     <= '0;
            vld_sr     <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx_sr[i] <= '0;
            end
            for (int i = 0; i < FDEPTH; i++) begin
                mem_data[i] <= '0;
                mem_idx[i]  <= '0;
            end
        end else begin
            if ((state == IDLE) && start) begin
                w_addr_q <= '0;
                if ((nrows_cfg == '0) || (int'(nrows_cfg) > NROWS)) begin
                    last_row <= ADDRW'(NROWS - 1);
                end else begin
                    last_row <= nrows_cfg - ADDRW'(1);
                end
            end else if (issue) begin
                w_addr_q <= w_addr_q + ADDRW'(1);
            end

            vm_en_q   <= issue;
            vm_idx    <= w_addr_q;
            vld_sr[0] <= vm_en_q;
            idx_sr[0] <= vm_idx;
            for (int i = 1; i < LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                idx_sr[i] <= idx_sr[i-1];
            end

            if (fifo_wr) begin
                mem_data[wr_ptr] <= bus.vm_result;
                mem_idx[wr_ptr]  <= idx_sr[LAT-1];
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            inflight   <= inflight + CW'(issue) - CW'(fifo_wr);
            fifo_count <= fifo_count + CW'(fifo_wr) - CW'(pop);

            // Abort drops everything still travelling through the datapath and the FIFO.
            if (abort_hit) begin
                vm_en_q    <= 1'b0;
                vld_sr     <= '0;
                inflight   <= '0;
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end
        end
    end

    assign bus.w_rd_en   = issue;
    assign bus.w_addr    = w_addr_q;
    assign bus.vm_en     = vm_en_q;
    assign bus.res_valid = (fifo_count != '0);
    assign bus.res_data  = mem_data[rd_ptr];
    assign bus.res_idx   = mem_idx[rd_ptr];
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

endmodule

// File: tb/tb_vecmat_row_sched.sv
// Directed bench for vecmat_row_sched; models weight RAM + datapath as result = row*mult.
// Abort steps are compiled in when VECMAT_SCHED_ABORT_EN is defined.
module tb_vecmat_row_sched;

    localparam int NROWS  = 100;
    localparam int ADDRW  = 7;
    localparam int DW     = 16;
    localparam int LAT    = 2;
    localparam int FDEPTH = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [ADDRW-1:0] nrows_cfg;
    logic             busy;
    logic             done;
`ifdef VECMAT_SCHED_ABORT_EN
    logic             abort;
`endif

    int checks;
    int errors;
    int mult;

    logic [ADDRW-1:0] pipe_addr [LAT+1];
    logic             pipe_vld  [LAT+1];

    vecmat_row_sched_if #(.ADDRW(ADDRW), .DW(DW)) bus ();

    vecmat_row_sched #(
        .NROWS (NROWS),
        .ADDRW (ADDRW),
        .DW    (DW),
        .LAT   (LAT),
        .FDEPTH(FDEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .nrows_cfg(nrows_cfg),
`ifdef VECMAT_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read (1 cycle) followed by LAT datapath stages; garbage when nothing is due.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= bus.w_rd_en;
            pipe_addr[0] <= bus.w_addr;
            for (int i = 1; i <= LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    always_comb begin
        bus.vm_result = pipe_vld[LAT] ? DW'(int'(pipe_addr[LAT]) * mult) : 16'hDEAD;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle; afterwards nrows_cfg holds a decoy value.
    task automatic applyStimulus(input logic [ADDRW-1:0] n);
        nrows_cfg = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        nrows_cfg = 7'd3;
    endtask

    // Called on the negedge of the first cycle after start; cycle 1 is that cycle.
    task automatic runPass(input int n_exp, input int exp_done, input int stall_until,
                           input int pulse_a, input int pulse_b);
        int cyc;
        int got;
        int n_done;
        int done_cyc;
        int stall_issues;
        logic busy_bad;
        cyc          = 1;
        got          = 0;
        n_done       = 0;
        done_cyc     = -1;
        stall_issues = 0;
        busy_bad     = 1'b0;
        while (cyc < 400) begin
            bus.res_ready = (cyc > stall_until);
            start         = (cyc == pulse_a) || (cyc == pulse_b);
            if ((done_cyc < 0) && (busy !== 1'b1)) busy_bad = 1'b1;
            if (bus.w_rd_en && (cyc <= stall_until)) stall_issues++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (got < n_exp) begin
                    checkOutput("res_idx", 32'(bus.res_idx), 32'(got));
                    checkOutput("res_data", 32'(bus.res_data), 32'(DW'(got * mult)));
                end
                got++;
            end
            if ((done_cyc >= 0) && (cyc >= done_cyc + 3)) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput("pass_finished", 32'(done_cyc >= 0), 32'd1);
        checkOutput("result_count", 32'(got), 32'(n_exp));
        checkOutput("done_pulses", 32'(n_done), 32'd1);
        checkOutput("busy_held", 32'(busy_bad), 32'd0);
        checkOutput("busy_after", 32'(busy), 32'd0);
        if (exp_done >= 0) checkOutput("done_cycle", 32'(done_cyc), 32'(exp_done));
        if (stall_until > 0) checkOutput("issues_in_stall", 32'(stall_issues), 32'(FDEPTH));
    endtask

    initial begin
        int k;
        checks        = 0;
        errors        = 0;
        mult          = 3;
        reset         = 1'b1;
        start         = 1'b0;
        nrows_cfg     = '0;
        bus.res_ready = 1'b0;
`ifdef VECMAT_SCHED_ABORT_EN
        abort         = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_w_rd_en", 32'(bus.w_rd_en), 32'd0);
        checkOutput("rst_vm_en", 32'(bus.vm_en), 32'd0);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst_w_addr", 32'(bus.w_addr), 32'd0);
        checkOutput("rst_res_idx", 32'(bus.res_idx), 32'd0);
        checkOutput("rst_res_data", 32'(bus.res_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] 5-row pass, data row*3, done expected at cycle %0d", 4 + LAT + 4);
        mult          = 3;
        bus.res_ready = 1'b1;
        applyStimulus(7'd5);
        checkOutput("first_issue_en", 32'(bus.w_rd_en), 32'd1);
        checkOutput("first_issue_addr", 32'(bus.w_addr), 32'd0);
        runPass(5, 4 + LAT + 4, 0, 0, 0);

        $display("[TB] minimum pass N=1");
        mult = 7;
        applyStimulus(7'd1);
        runPass(1, 4 + LAT, 0, 0, 0);

        $display("[TB] reset at row 37 of a full pass");
        mult = 5;
        applyStimulus(7'd0);
        k = 0;
        while ((k < 200) && !(bus.w_rd_en && (bus.w_addr == 7'd37))) begin
            @(negedge clk);
            k++;
        end
        checkOutput("reached_row37", 32'(k < 200), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("midrst_w_rd_en", 32'(bus.w_rd_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postrst_valid", 32'(bus.res_valid), 32'd0);
        applyStimulus(7'd5);
        checkOutput("restart_addr", 32'(bus.w_addr), 32'd0);
        runPass(5, 4 + LAT + 4, 0, 0, 0);

        $display("[TB] nrows_cfg=0 runs the full 100 rows");
        mult = 5;
        applyStimulus(7'd0);
        runPass(NROWS, NROWS + LAT + 3, 0, 0, 0);

        $display("[TB] nrows_cfg=101 clamps to 100 rows");
        mult = 2;
        applyStimulus(7'd101);
        runPass(NROWS, NROWS + LAT + 3, 0, 0, 0);

        $display("[TB] consumer stalled for 20 cycles, N=10");
        mult = 11;
        applyStimulus(7'd10);
        runPass(10, -1, 20, 0, 0);

        $display("[TB] start pulsed at rows 3 and 7 of a 10-row pass");
        mult          = 9;
        bus.res_ready = 1'b1;
        applyStimulus(7'd10);
        runPass(10, 10 + LAT + 3, 0, 4, 8);

`ifdef VECMAT_SCHED_ABORT_EN
        $display("[TB] abort at row 4 of 50");
        mult = 3;
        applyStimulus(7'd50);
        k = 0;
        while ((k < 100) && !(bus.w_rd_en && (bus.w_addr == 7'd4))) begin
            @(negedge clk);
            k++;
        end
        checkOutput("reached_row4", 32'(k < 100), 32'd1);
        abort = 1'b1;
        #1;
        checkOutput("abort_issue_stop", 32'(bus.w_rd_en), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd1);
        checkOutput("abort_busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("abort_done_drop", 32'(done), 32'd0);
        checkOutput("abort_busy_drop", 32'(busy), 32'd0);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.res_valid || done || bus.w_rd_en) k++;
            @(negedge clk);
        end
        checkOutput("abort_quiet", 32'(k), 32'd0);
        applyStimulus(7'd3);
        runPass(3, 3 + LAT + 3, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
